audio_mix_scheduler: RTL and testbench

Sequences the single-port audio sample memory between a looping background-music stream and a one-shot sound-effect stream. It generates the sample-rate tick after codec initialisation completes and issues both memory reads per tick. It then mixes the two samples with saturation and presents one 16-bit sample to the codec output path. It sits between the codec init/config logic and the sample ROM/SRAM and replaces free-running single-stream address generation.

---
 rtl/audio_mix_scheduler.sv | 153 +++++++++++++++
 tb/tb_audio_mix_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_scheduler.sv
// Two-stream sample sequencer: looping music plus one-shot effect share one memory port,
// mixed with saturation once per sample tick.
module audio_mix_scheduler #(
    parameter int ADDR_W    = 17,
    parameter int TICK_DIV  = 92,
    parameter int MUSIC_END = 54831
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     INIT_FINISH,
    output logic                     INIT,
    input  logic                     Music_en,
    input  logic                     Sfx_start,
    input  logic [ADDR_W-1:0]        Sfx_base,
    input  logic [ADDR_W-1:0]        Sfx_len,
    output logic [ADDR_W-1:0]        Mem_addr,
    input  logic signed [15:0]       Mem_data,
    output logic signed [15:0]       Sample,
    output logic                     Sample_valid,
    output logic                     Sfx_busy,
    output logic                     Sfx_done
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] M_END = ADDR_W'(MUSIC_END);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_FETCH_M,
        S_LATCH_M,
        S_FETCH_S,
        S_LATCH_S,
        S_MIX
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              trig;
    logic [ADDR_W-1:0] music_addr;
    logic [ADDR_W-1:0] sfx_addr;
    logic [ADDR_W-1:0] sfx_rem;
    logic              sfx_fetch_ok;
    logic              sfx_take;
    logic signed [15:0] m_q;
    logic signed [15:0] s_q;
    logic signed [16:0] mix_sum;
    logic signed [15:0] mix_sat;

    assign tick     = (state_q == S_IDLE) && (tick_cnt == CNT_LAST);
    assign trig     = Sfx_start && (state_q != S_WAIT_INIT);
    assign sfx_take = (state_q == S_LATCH_S) && Sfx_busy && sfx_fetch_ok;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_WAIT_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_INIT: if (INIT_FINISH) state_d = S_IDLE;
            S_IDLE:      if (tick) state_d = S_FETCH_M;
            S_FETCH_M:   state_d = S_LATCH_M;
            S_LATCH_M:   state_d = S_FETCH_S;
            S_FETCH_S:   state_d = S_LATCH_S;
            S_LATCH_S:   state_d = S_MIX;
            S_MIX:       state_d = S_IDLE;
            default:     state_d = S_WAIT_INIT;
        endcase
    end

    // Counter runs through the whole fetch/mix sequence so ticks stay exactly periodic.
    always_ff @(posedge Clk) begin
        if (Reset || state_q == S_WAIT_INIT) tick_cnt <= '0;
        else if (tick_cnt == CNT_LAST)       tick_cnt <= '0;
        else                                 tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_comb begin
        mix_sum = {m_q[15], m_q} + {s_q[15], s_q};
        if (mix_sum[16] != mix_sum[15])
            mix_sat = mix_sum[16] ? 16'sh8000 : 16'sh7FFF;
        else
            mix_sat = mix_sum[15:0];
    end

    // Address is presented during the FETCH cycle so data lands in the LATCH cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            INIT         <= 1'b0;
            Mem_addr     <= '0;
            music_addr   <= '0;
            m_q          <= '0;
            Sample       <= '0;
            Sample_valid <= 1'b0;
        end else begin
            INIT         <= 1'b1;
            Sample_valid <= 1'b0;
            if (tick) Mem_addr <= music_addr;
            if (state_q == S_LATCH_M) begin
                Mem_addr <= trig ? Sfx_base : sfx_addr;
                if (Music_en) begin
                    m_q        <= Mem_data;
                    music_addr <= (music_addr == M_END) ? '0 : music_addr + A_ONE;
                end else begin
                    m_q <= '0;
                end
            end
            if (state_q == S_MIX) begin
                Sample       <= mix_sat;
                Sample_valid <= 1'b1;
            end
        end
    end

    // fetch_ok marks that the address on the bus belongs to the effect now playing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sfx_addr     <= '0;
            sfx_rem      <= '0;
            sfx_fetch_ok <= 1'b0;
            s_q          <= '0;
            Sfx_busy     <= 1'b0;
            Sfx_done     <= 1'b0;
        end else begin
            Sfx_done <= 1'b0;
            if (state_q == S_LATCH_M)
                sfx_fetch_ok <= trig ? (Sfx_len != '0) : Sfx_busy;
            else if (state_q == S_FETCH_S && trig)
                sfx_fetch_ok <= 1'b0;
            if (state_q == S_LATCH_S)
                s_q <= sfx_take ? Mem_data : 16'sh0000;
            if (trig) begin
                sfx_addr <= Sfx_base;
                sfx_rem  <= Sfx_len;
                Sfx_busy <= (Sfx_len != '0);
            end else if (sfx_take) begin
                sfx_addr <= sfx_addr + A_ONE;
                sfx_rem  <= sfx_rem - A_ONE;
                if (sfx_rem == A_ONE) begin
                    Sfx_busy <= 1'b0;
                    Sfx_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Scoreboard bench for audio_mix_scheduler: per-tick reference model feeds a queue,
// a negedge monitor pops on every Sample_valid.
module tb_audio_mix_scheduler;

    localparam int AW = 17;
    localparam int TD = 92;
    localparam int ME = 3;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               INIT_FINISH;
    logic               INIT;
    logic               Music_en;
    logic               Sfx_start;
    logic [AW-1:0]      Sfx_base;
    logic [AW-1:0]      Sfx_len;
    logic [AW-1:0]      Mem_addr;
    logic signed [15:0] Mem_data;
    logic signed [15:0] Sample;
    logic               Sample_valid;
    logic               Sfx_busy;
    logic               Sfx_done;

    audio_mix_scheduler #(.ADDR_W(AW), .TICK_DIV(TD), .MUSIC_END(ME)) dut (
        .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
        .Music_en(Music_en), .Sfx_start(Sfx_start), .Sfx_base(Sfx_base),
        .Sfx_len(Sfx_len), .Mem_addr(Mem_addr), .Mem_data(Mem_data),
        .Sample(Sample), .Sample_valid(Sample_valid), .Sfx_busy(Sfx_busy),
        .Sfx_done(Sfx_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] sample;
        bit          done;
        bit          busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   first_cyc = 0;
    bit   first_pending = 0;
    int   last_cyc = 0;
    bit   prev_done = 0;

    // Memory content: address-as-data, or fixed music/effect values.
    bit                 ovr = 0;
    logic signed [15:0] mval = 0;
    logic signed [15:0] sval = 0;

    // Reference model state
    logic [AW-1:0] music_idx = '0;
    logic [AW-1:0] md_ptr = '0;
    logic [AW-1:0] md_rem = '0;

    function automatic logic signed [15:0] dataf(input logic [AW-1:0] a);
        if (ovr) return (a <= AW'(ME)) ? mval : sval;
        return a[15:0];
    endfunction

    function automatic logic [15:0] sat(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    always @(posedge Clk) Mem_data <= dataf(Mem_addr);
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset !== 1'b1 && Sample_valid === 1'b1) begin
            if (first_pending) begin
                chk("first_valid_cycle", cyc, first_cyc);
                first_pending = 0;
            end else begin
                chk("valid_period", cyc - last_cyc, TD);
            end
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample", {16'h0, Sample}, {16'h0, e.sample});
                chk("done_before_valid", {31'h0, prev_done}, {31'h0, e.done});
                chk("busy_at_valid", {31'h0, Sfx_busy}, {31'h0, e.busy});
            end
        end
        if (Sfx_done === 1'b1) done_cnt++;
        prev_done = (Sfx_done === 1'b1);
    end

    // One sample period: apply stimulus, predict its sample, wait for it.
    task automatic period(input bit en, input bit trig,
                          input logic [AW-1:0] base, input logic [AW-1:0] len);
        exp_t e;
        int   m;
        int   s;
        bit   got;
        Music_en = en;
        if (trig) begin
            Sfx_start = 1'b1;
            Sfx_base  = base;
            Sfx_len   = len;
            md_ptr    = base;
            md_rem    = len;
        end
        m = 0;
        if (en) begin
            m = int'(dataf(music_idx));
            music_idx = (music_idx == AW'(ME)) ? '0 : music_idx + AW'(1);
        end
        s = 0;
        e.done = 0;
        if (md_rem != 0) begin
            s = int'(dataf(md_ptr));
            md_ptr = md_ptr + AW'(1);
            md_rem = md_rem - AW'(1);
            if (md_rem == 0) begin
                e.done = 1;
                exp_done++;
            end
        end
        e.sample = sat(m + s);
        e.busy = (md_rem != 0);
        exp_q.push_back(e);
        @(negedge Clk);
        Sfx_start = 1'b0;
        if (trig) chk("busy_after_start", {31'h0, Sfx_busy}, {31'h0, len != 0});
        got = 0;
        for (int n = 0; n < 200; n++) begin
            if (Sample_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge Clk);
        end
        if (!got) chk("sample_timeout", 0, 1);
    endtask

    task automatic start_init();
        INIT_FINISH = 1'b1;
        first_cyc = cyc + 98;
        first_pending = 1;
        repeat (3) @(negedge Clk);
        INIT_FINISH = 1'b0;
    endtask

    task automatic chk_reset_outs(input logic want_init);
        chk("rst_init", {31'h0, INIT}, {31'h0, want_init});
        chk("rst_mem_addr", {15'h0, Mem_addr}, 32'h0);
        chk("rst_sample", {16'h0, Sample}, 32'h0);
        chk("rst_valid", {31'h0, Sample_valid}, 32'h0);
        chk("rst_busy", {31'h0, Sfx_busy}, 32'h0);
        chk("rst_done", {31'h0, Sfx_done}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1;
        INIT_FINISH = 1'b0;
        Music_en = 1'b0;
        Sfx_start = 1'b0;
        Sfx_base = '0;
        Sfx_len = '0;
        repeat (4) begin
            @(negedge Clk);
            chk_reset_outs(1'b0);
        end
        Reset = 1'b0;

        // Held in WAIT_INIT: effect triggers must be ignored.
        for (int i = 0; i < 300; i++) begin
            Sfx_start = (i % 50 == 10);
            Sfx_base = AW'(17'h40);
            Sfx_len = AW'(5);
            @(negedge Clk);
            chk_reset_outs(1'b1);
        end
        Sfx_start = 1'b0;

        start_init();

        for (int i = 0; i < 6; i++) period(1, 0, '0, '0);

        period(0, 1, AW'(17'h100), AW'(3));
        period(0, 0, '0, '0);
        period(0, 0, '0, '0);
        period(0, 0, '0, '0);

        ovr = 1;
        mval = 16'sh7000; sval = 16'sh7000;
        period(1, 1, AW'(17'h100), AW'(1));
        mval = 16'sh9000; sval = 16'sh9000;
        period(1, 1, AW'(17'h100), AW'(1));
        mval = 16'sh7000; sval = 16'sh9000;
        period(1, 1, AW'(17'h100), AW'(1));
        ovr = 0;

        period(0, 1, AW'(17'h300), AW'(5));
        period(0, 1, AW'(17'h200), AW'(2));
        period(0, 0, '0, '0);
        period(0, 0, '0, '0);

        period(0, 1, AW'(17'h400), AW'(4));
        period(0, 1, AW'(17'h010), AW'(0));
        period(1, 1, AW'(17'h010), AW'(0));

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] b;
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0)      b = AW'(17'h07FFD);
            else if (r == 1) b = AW'(17'h1FFFE);
            else             b = AW'($urandom);
            period(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   b, AW'($urandom_range(0, 4)));
        end

        // Reset while the effect fetch is on the bus.
        Music_en = 1'b1;
        repeat (89) @(negedge Clk);
        Reset = 1'b1;
        exp_q.delete();
        music_idx = '0;
        md_rem = '0;
        repeat (3) begin
            @(negedge Clk);
            chk_reset_outs(1'b0);
        end
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            chk_reset_outs(1'b1);
        end
        start_init();
        period(1, 0, '0, '0);
        period(1, 0, '0, '0);

        repeat (3) @(negedge Clk);
        chk("done_total", done_cnt, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
